// File: rtl/spike_issue_queue.sv
// -----------------------------------------------------------------------------
// spike_issue_queue
//   Upstream feeder for the TCAM routing memory. Neuron fire events (packet
//   IDs) are buffered in a FIFO and issued to the memory at most once per
//   cycle as a compare lookup. Issue is held while the memory is busy with
//   configuration traffic. A small tracking pipeline follows every lookup so
//   the consumer sees the source ID aligned with the memory's result.
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   Spike_Valid_In   in   fire event present
//   Spike_ID_In      in   firing neuron packet ID
//   Spike_Ready_Out  out  queue can accept an event this cycle
//   Flush_In         in   synchronous clear of queue and tracking
//   Cfg_Busy_In      in   memory busy; no lookups allowed
//   CS_Out           out  memory chip select for the lookup
//   CMP_Out          out  memory compare strobe
//   PacketID_Out     out  lookup key to the memory
//   Result_Valid_Out out  memory output this cycle belongs to a lookup
//   Result_ID_Out    out  source ID of that lookup
//   Count_Out        out  current FIFO occupancy, 0..Depth
// -----------------------------------------------------------------------------
module spike_issue_queue #(
  parameter int ID_Width    = 4,
  parameter int Depth       = 8,
  parameter int PtrWidth    = 3,
  parameter int Mem_Latency = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Spike_Valid_In,
  input  logic [ID_Width-1:0] Spike_ID_In,
  output logic                Spike_Ready_Out,
  input  logic                Flush_In,
  input  logic                Cfg_Busy_In,
  output logic                CS_Out,
  output logic                CMP_Out,
  output logic [ID_Width-1:0] PacketID_Out,
  output logic                Result_Valid_Out,
  output logic [ID_Width-1:0] Result_ID_Out,
  output logic [PtrWidth:0]   Count_Out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam logic [PtrWidth:0]   C_DEPTH   = (PtrWidth+1)'(Depth);
  localparam logic [PtrWidth:0]   C_CNT_ONE = {{PtrWidth{1'b0}}, 1'b1};
  localparam logic [PtrWidth:0]   C_CNT_0   = {(PtrWidth+1){1'b0}};
  localparam logic [PtrWidth-1:0] C_PTR_ONE = {{(PtrWidth-1){1'b0}}, 1'b1};
  localparam logic [PtrWidth-1:0] C_PTR_0   = {PtrWidth{1'b0}};
  localparam logic [ID_Width-1:0] C_ID_0    = {ID_Width{1'b0}};

  logic [ID_Width-1:0]    r_mem [Depth];
  logic [PtrWidth-1:0]    r_wr_ptr;
  logic [PtrWidth-1:0]    r_rd_ptr;
  logic [PtrWidth:0]      r_count;
  state_t                 r_state;
  logic                   r_cs;
  logic                   r_cmp;
  logic [ID_Width-1:0]    r_pkt_id;
  logic [Mem_Latency-1:0] r_trk_vld;
  logic [ID_Width-1:0]    r_trk_id [Mem_Latency];

  logic                   w_ready;
  logic                   w_push;
  logic                   w_pop;
  logic [PtrWidth:0]      w_count_nxt;

  // Ready depends only on the registered count, so a full queue refuses an
  // event even when a pop happens on the same edge.
  assign w_ready = (r_count != C_DEPTH);
  assign w_push  = Spike_Valid_In & w_ready & ~Flush_In;
  // STALL may pop on the very edge busy drops, so a busy pulse of N cycles
  // leaves a strobe gap of exactly N cycles. IDLE always means count == 0.
  assign w_pop   = (r_state != S_IDLE) & (r_count != C_CNT_0) &
                   ~Cfg_Busy_In & ~Flush_In;

  // Next occupancy from the push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + C_CNT_ONE;
      2'b01:   w_count_nxt = r_count - C_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage and pointers; flush rewinds both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= C_PTR_0;
      r_rd_ptr <= C_PTR_0;
      r_count  <= C_CNT_0;
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= C_ID_0;
      end
    end else if (Flush_In) begin
      r_wr_ptr <= C_PTR_0;
      r_rd_ptr <= C_PTR_0;
      r_count  <= C_CNT_0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= Spike_ID_In;
        r_wr_ptr        <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_count <= w_count_nxt;
    end
  end

  // Issue FSM with registered lookup strobes and key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cs     <= 1'b0;
      r_cmp    <= 1'b0;
      r_pkt_id <= C_ID_0;
    end else if (Flush_In) begin
      r_state <= S_IDLE;
      r_cs    <= 1'b0;
      r_cmp   <= 1'b0;
    end else begin
      r_cs  <= w_pop;
      r_cmp <= w_pop;
      if (w_pop) begin
        r_pkt_id <= r_mem[r_rd_ptr];
      end
      case (r_state)
        S_IDLE: begin
          if (w_count_nxt != C_CNT_0) r_state <= S_RUN;
          else                        r_state <= S_IDLE;
        end
        S_RUN, S_STALL: begin
          if (Cfg_Busy_In)                 r_state <= S_STALL;
          else if (w_count_nxt == C_CNT_0) r_state <= S_IDLE;
          else                             r_state <= S_RUN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tracking pipeline: each stage carries {valid, ID} of one lookup so the
  // last stage lines up with the memory's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trk_vld <= {Mem_Latency{1'b0}};
      for (int i = 0; i < Mem_Latency; i++) begin
        r_trk_id[i] <= C_ID_0;
      end
    end else begin
      r_trk_id[0] <= r_pkt_id;
      for (int i = 1; i < Mem_Latency; i++) begin
        r_trk_id[i] <= r_trk_id[i-1];
      end
      if (Flush_In) begin
        r_trk_vld <= {Mem_Latency{1'b0}};
      end else begin
        r_trk_vld[0] <= r_cmp;
        for (int i = 1; i < Mem_Latency; i++) begin
          r_trk_vld[i] <= r_trk_vld[i-1];
        end
      end
    end
  end

  assign Spike_Ready_Out  = w_ready;
  assign CS_Out           = r_cs;
  assign CMP_Out          = r_cmp;
  assign PacketID_Out     = r_pkt_id;
  assign Result_Valid_Out = r_trk_vld[Mem_Latency-1];
  assign Result_ID_Out    = r_trk_id[Mem_Latency-1];
  assign Count_Out        = r_count;

endmodule

// File: tb/tb_spike_issue_queue.sv
module tb_spike_issue_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Spike_Valid_In = 1'b0;
  logic [3:0] Spike_ID_In = 4'd0;
  logic       Spike_Ready_Out;
  logic       Flush_In = 1'b0;
  logic       Cfg_Busy_In = 1'b0;
  logic       CS_Out, CMP_Out;
  logic [3:0] PacketID_Out;
  logic       Result_Valid_Out;
  logic [3:0] Result_ID_Out;
  logic [3:0] Count_Out;

  spike_issue_queue #(.ID_Width(4), .Depth(8), .PtrWidth(3), .Mem_Latency(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .Spike_Valid_In(Spike_Valid_In), .Spike_ID_In(Spike_ID_In),
    .Spike_Ready_Out(Spike_Ready_Out), .Flush_In(Flush_In),
    .Cfg_Busy_In(Cfg_Busy_In), .CS_Out(CS_Out), .CMP_Out(CMP_Out),
    .PacketID_Out(PacketID_Out), .Result_Valid_Out(Result_Valid_Out),
    .Result_ID_Out(Result_ID_Out), .Count_Out(Count_Out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  // Behavioural model: a plain queue of waiting IDs, the last issued
  // lookup, and a two-deep delay line of {valid,id} for the results.
  int         mq[$];
  bit         m_cmp;
  int         m_pkt;
  bit         m_v0, m_v1;
  int         m_i0, m_i1;

  int iss_log[$], iss_cyc[$], res_log[$], res_cyc[$], acc_log[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cmp = 1'b0; m_pkt = 0;
    m_v0 = 1'b0; m_v1 = 1'b0; m_i0 = 0; m_i1 = 0;
  endtask

  // One clock edge of the model, from the inputs present at that edge.
  task automatic model_step();
    bit push, pop;
    m_v1 = m_v0; m_i1 = m_i0;
    m_v0 = m_cmp; m_i0 = m_pkt;
    if (Flush_In) begin
      mq.delete();
      m_cmp = 1'b0;
      m_v0 = 1'b0; m_v1 = 1'b0;
    end else begin
      push = Spike_Valid_In && (mq.size() < 8);
      pop  = (mq.size() != 0) && !Cfg_Busy_In;
      if (pop) begin
        m_pkt = mq.pop_front();
        m_cmp = 1'b1;
      end else begin
        m_cmp = 1'b0;
      end
      if (push) begin
        mq.push_back(int'(Spike_ID_In));
        acc_log.push_back(int'(Spike_ID_In));
      end
    end
  endtask

  // Compare process: DUT against the model every cycle, plus strobe logs.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (CMP_Out === 1'b1) begin
        iss_log.push_back(int'(PacketID_Out));
        iss_cyc.push_back(cyc);
      end
      if (Result_Valid_Out === 1'b1) begin
        res_log.push_back(int'(Result_ID_Out));
        res_cyc.push_back(cyc);
      end
    end
    if (chk_en) begin
      chk("cs",     int'(CS_Out),           int'(m_cmp));
      chk("cmp",    int'(CMP_Out),          int'(m_cmp));
      chk("pkt_id", int'(PacketID_Out),     m_pkt);
      chk("count",  int'(Count_Out),        mq.size());
      chk("ready",  int'(Spike_Ready_Out),  int'(mq.size() != 8));
      chk("res_vld", int'(Result_Valid_Out), int'(m_v1));
      if (m_v1) chk("res_id", int'(Result_ID_Out), m_i1);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int id, input bit busy, input bit fl);
    Spike_Valid_In = v;
    Spike_ID_In    = 4'(id);
    Cfg_Busy_In    = busy;
    Flush_In       = fl;
  endtask

  task automatic clear_logs();
    iss_log.delete(); iss_cyc.delete();
    res_log.delete(); res_cyc.delete(); acc_log.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  int'(Spike_Ready_Out), 1);
    chk({tag, "_count"},  int'(Count_Out), 0);
    chk({tag, "_cs"},     int'(CS_Out), 0);
    chk({tag, "_cmp"},    int'(CMP_Out), 0);
    chk({tag, "_pkt"},    int'(PacketID_Out), 0);
    chk({tag, "_resv"},   int'(Result_Valid_Out), 0);
    chk({tag, "_resid"},  int'(Result_ID_Out), 0);
  endtask

  initial begin
    int base, fcyc, late;
    int ids2[3];
    ids2[0] = 3; ids2[1] = 7; ids2[2] = 12;

    // Power-on reset
    model_reset();
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Three back-to-back events, memory idle
    clear_logs();
    base = cyc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ids2[i], 1'b0, 1'b0); tick();
    end
    drive(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_iss_n", iss_log.size(), 3);
    chk("t2_res_n", res_log.size(), 3);
    if (iss_log.size() == 3 && res_log.size() == 3) begin
      chk("t2_first_cmp_cyc", iss_cyc[0], base + 2);
      for (int i = 0; i < 3; i++) begin
        chk("t2_iss_id", iss_log[i], ids2[i]);
        chk("t2_iss_cyc", iss_cyc[i], base + 2 + i);
        chk("t2_res_id", res_log[i], ids2[i]);
        chk("t2_res_lat", res_cyc[i] - iss_cyc[i], 2);
      end
    end

    // Fill under busy, hold a 9th event, then release
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i + 1, 1'b1, 1'b0); tick();
    end
    chk("t3_count_full", int'(Count_Out), 8);
    chk("t3_ready_full", int'(Spike_Ready_Out), 0);
    drive(1'b1, 9, 1'b1, 1'b0);
    tick(); tick();
    chk("t3_count_held", int'(Count_Out), 8);
    drive(1'b1, 9, 1'b0, 1'b0);
    tick();
    chk("t3_count_after_pop", int'(Count_Out), 7);
    tick();
    drive(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    chk("t3_iss_n", iss_log.size(), 9);
    if (iss_log.size() == 9)
      for (int i = 0; i < 9; i++) chk("t3_order", iss_log[i], i + 1);

    // Busy pulse of two cycles mid-drain
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10 + i, 1'b1, 1'b0); tick();
    end
    drive(1'b0, 0, 1'b0, 1'b0); tick(); tick();
    drive(1'b0, 0, 1'b1, 1'b0); tick(); tick();
    drive(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("t4_iss_n", iss_log.size(), 5);
    if (iss_log.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("t4_order", iss_log[i], 10 + i);
      chk("t4_step01", iss_cyc[1] - iss_cyc[0], 1);
      chk("t4_gap",    iss_cyc[2] - iss_cyc[1], 3);
      chk("t4_step23", iss_cyc[3] - iss_cyc[2], 1);
    end

    // Flush with four queued and two in flight
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i + 1, 1'b1, 1'b0); tick();
    end
    drive(1'b0, 0, 1'b0, 1'b0); tick(); tick();
    chk("t5_count_pre", int'(Count_Out), 4);
    drive(1'b1, 15, 1'b0, 1'b1); tick();
    fcyc = cyc;
    chk("t5_count_post", int'(Count_Out), 0);
    chk("t5_ready_post", int'(Spike_Ready_Out), 1);
    drive(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    late = 0;
    foreach (iss_cyc[i]) if (iss_cyc[i] >= fcyc) late++;
    foreach (res_cyc[i]) if (res_cyc[i] >= fcyc) late++;
    chk("t5_strobes_after_flush", late, 0);
    chk("t5_iss_before", iss_log.size(), 2);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5 + i, 1'b1, 1'b0); tick();
    end
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("t1_count_pre", int'(Count_Out), 3);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async");
    tick();
    chk_reset_outputs("held");
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    tick();

    // Random push/busy stress with an end-to-end order scoreboard
    clear_logs();
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) < 60, int'($urandom_range(0, 15)),
            $urandom_range(0, 99) < 25, 1'b0);
      tick();
    end
    drive(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    chk("t6_count_drained", int'(Count_Out), 0);
    chk("t6_iss_n", iss_log.size(), acc_log.size());
    chk("t6_res_n", res_log.size(), iss_log.size());
    if (iss_log.size() == acc_log.size())
      foreach (acc_log[i]) chk("t6_order", iss_log[i], acc_log[i]);
    if (res_log.size() == iss_log.size())
      foreach (iss_log[i]) chk("t6_res_lat", res_cyc[i] - iss_cyc[i], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
